cbd_stream_sampler: RTL and testbench

Streaming, parametrised centered-binomial sampler for Kyber polynomial noise generation. It consumes the PRF output stream in IN_W-bit beats and supports eta = 2 or eta = 3, selected at run time. It emits the 256 coefficients of one polynomial, one per cycle, over a valid/ready interface. It sits between the PRF/XOF output buffer and the NTT/polynomial RAM write port.

---
 rtl/cbd_pkg.sv | 9 +
 rtl/cbd_coef.sv | 33 +++
 rtl/cbd_stream_sampler.sv | 102 ++++++++++
 tb/tb_cbd_stream_sampler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cbd_pkg.sv
// Shared constants and types for the centered-binomial noise sampler.
package cbd_pkg;
  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 12;

  typedef enum logic {ETA2 = 1'b0, ETA3 = 1'b1} eta_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/cbd_coef.sv
// One CBD coefficient from a 2*eta-bit group (low eta bits minus high eta bits).
// CBD_MODQ_EN selects unsigned mod-q output; otherwise 12-bit two's complement.
module cbd_coef
  import cbd_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic [5:0]        grp,
  input  eta_e              eta,
  output logic [COEF_W-1:0] coef
);
  logic [2:0]        a, b;
  logic signed [3:0] f;

  always_comb begin
    if (eta == ETA3) begin
      a = 3'(grp[0]) + 3'(grp[1]) + 3'(grp[2]);
      b = 3'(grp[3]) + 3'(grp[4]) + 3'(grp[5]);
    end else begin
      a = 3'(grp[0]) + 3'(grp[1]);
      b = 3'(grp[2]) + 3'(grp[3]);
    end
    f = $signed({1'b0, a}) - $signed({1'b0, b});
  end

`ifdef CBD_MODQ_EN
  logic [3:0] mag;
  assign mag  = f[3] ? 4'(-f) : 4'(f);
  assign coef = f[3] ? COEF_W'(Q) - COEF_W'(mag) : COEF_W'(mag);
`else
  assign coef = {{(COEF_W-4){f[3]}}, f};
`endif
endmodule

// File: rtl/cbd_stream_sampler.sv
// Streaming CBD sampler: PRF beats in, one coefficient per cycle out.
// Output format follows CBD_MODQ_EN (see cbd_coef).
module cbd_stream_sampler
  import cbd_pkg::*;
#(
  parameter int IN_W = 64,
  parameter int N    = KYBER_N,
  parameter int Q    = KYBER_Q
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              eta_sel,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [COEF_W-1:0] coef_o,
  output logic [7:0]        coef_idx,
  output logic              coef_last,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy,
  output logic              done
);
  localparam int BUF_W  = IN_W + 8;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int CNT_W  = $clog2(N + 1);

  state_e            state;
  eta_e              eta;
  logic [BUF_W-1:0]  sbuf;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  pops;
  logic [FILL_W-1:0] need;
  logic [COEF_W-1:0] coef;
  logic              beat, pop, xfer;

  assign need = (eta == ETA3) ? FILL_W'(6) : FILL_W'(4);
  // Input stops once all N groups are popped, so a late beat is never swallowed.
  assign in_ready = (state == RUN) && (fill < need) && (pops < CNT_W'(N));
  assign beat     = in_valid && in_ready;
  assign pop      = (state == RUN) && (fill >= need) && (!coef_valid || coef_ready)
                    && (pops < CNT_W'(N));
  assign xfer     = coef_valid && coef_ready;
  assign busy     = (state == RUN);

  cbd_coef #(.Q(Q)) u_coef (
    .grp  (sbuf[5:0]),
    .eta  (eta),
    .coef (coef)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      eta        <= ETA2;
      sbuf       <= '0;
      fill       <= '0;
      pops       <= '0;
      coef_o     <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      coef_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          eta   <= eta_e'(eta_sel);
          sbuf  <= '0;
          fill  <= '0;
          pops  <= '0;
        end
        RUN: begin
          // beat and pop are exclusive: one needs fill < need, the other fill >= need
          if (beat) begin
            sbuf <= sbuf | (BUF_W'(in_data) << fill);
            fill <= fill + FILL_W'(IN_W);
          end else if (pop) begin
            sbuf <= sbuf >> need;
            fill <= fill - need;
            pops <= pops + 1'b1;
          end
          if (pop) begin
            coef_o     <= coef;
            coef_idx   <= 8'(pops);
            coef_last  <= (pops == CNT_W'(N - 1));
            coef_valid <= 1'b1;
          end else if (xfer) begin
            coef_valid <= 1'b0;
          end
          if (xfer && coef_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cbd_stream_sampler.sv
// Scoreboard bench for cbd_stream_sampler: the bench models the CBD bit stream
// per accepted beat and compares every transferred coefficient.
module tb_cbd_stream_sampler;
  localparam int IN_W = 64;
  localparam int N    = 256;
  localparam int Q    = 3329;

  logic              clk = 1'b0;
  logic              rst_n, start, eta_sel, in_valid, in_ready;
  logic [IN_W-1:0]   in_data;
  logic [11:0]       coef_o;
  logic [7:0]        coef_idx;
  logic              coef_last, coef_valid, coef_ready, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cbd_stream_sampler #(.IN_W(IN_W), .N(N), .Q(Q)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .eta_sel    (eta_sel),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_o     (coef_o),
    .coef_idx   (coef_idx),
    .coef_last  (coef_last),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_coef(input int f);
`ifdef CBD_MODQ_EN
    return (f < 0) ? 12'(Q + f) : 12'(f);
`else
    return 12'(f);
`endif
  endfunction

  function automatic logic [IN_W-1:0] gen_beat(input int mode);
    logic [IN_W-1:0] v;
    v = '0;
    for (int k = 0; k < IN_W / 8; k++)
      case (mode)
        0:       v[8*k +: 8] = 8'h00;
        1:       v[8*k +: 8] = 8'h03;
        2:       v[8*k +: 8] = 8'h38;
        default: v[8*k +: 8] = 8'($urandom);
      endcase
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},   in_ready,   0);
    chk({tag, "_coef_valid"}, coef_valid, 0);
    chk({tag, "_coef_o"},     coef_o,     0);
    chk({tag, "_coef_idx"},   coef_idx,   0);
    chk({tag, "_coef_last"},  coef_last,  0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_done"},       done,       0);
  endtask

  // One polynomial; glitch pulses start with toggled eta_sel mid-run,
  // abort_at > 0 applies reset right after that many coefficients transfer.
  task automatic run_poly(input int e, input int mode, input int rdy_pct, input int vld_pct,
                          input bit glitch, input int abort_at);
    logic [IN_W-1:0] bt;
    logic [20:0]     exp_v;
    bit              bq[$];
    logic [20:0]     sq[$];
    int beats = 0, got = 0, pushed = 0, dones = 0, cyc = 0;
    bit fin = 0;
    bt = gen_beat(mode);
    @(posedge clk); #1 start = 1'b1; eta_sel = (e == 3);
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
    while (!fin && cyc < 20000) begin
      in_data    = bt;
      in_valid   = ($urandom_range(99) < vld_pct);
      coef_ready = ($urandom_range(99) < rdy_pct);
      start      = glitch && (cyc == 40);
      if (start) eta_sel = !eta_sel;
      @(negedge clk);
      if (in_valid && in_ready) begin
        beats++;
        for (int i = 0; i < IN_W; i++) bq.push_back(bt[i]);
        while (bq.size() >= 2 * e) begin
          int a = 0, b = 0;
          for (int i = 0; i < e; i++) a += int'(bq.pop_front());
          for (int i = 0; i < e; i++) b += int'(bq.pop_front());
          sq.push_back({pushed == N - 1, 8'(pushed), exp_coef(a - b)});
          pushed++;
        end
        bt = gen_beat(mode);
      end
      if (coef_valid && coef_ready) begin
        chk("sb_nonempty", sq.size() > 0, 1);
        if (sq.size() > 0) begin
          exp_v = sq.pop_front();
          chk("coef", coef_o, exp_v[11:0]);
          chk("idx", coef_idx, exp_v[19:12]);
          chk("last", coef_last, exp_v[20]);
        end
        got++;
        if (abort_at > 0 && got == abort_at) begin
          @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0; coef_ready = 1'b0; start = 1'b0;
          @(posedge clk); #1;
          check_reset("abort");
          rst_n = 1'b1;
          return;
        end
      end
      if (done) begin
        dones++;
        fin = 1'b1;
      end
      @(posedge clk); #1 cyc++;
    end
    chk("done_pulse", dones, 1);
    chk("beats", beats, 512 * e / IN_W);
    chk("coef_count", got, N);
    chk("sb_drain", sq.size(), 0);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("in_ready_idle", in_ready, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; eta_sel = 1'b0; in_valid = 1'b0;
    in_data = '0; coef_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    rst_n = 1'b1;
    run_poly(2, 0, 100, 100, 1'b0, 0);
    run_poly(2, 1, 100, 100, 1'b0, 0);
    run_poly(3, 2, 100, 100, 1'b0, 0);
    run_poly(2, 3, 70, 60, 1'b0, 0);
    run_poly(3, 3, 60, 70, 1'b1, 0);
    run_poly(2, 3, 50, 50, 1'b1, 0);
    run_poly(3, 3, 80, 80, 1'b0, 100);
    run_poly(2, 3, 80, 80, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
